arc4_encrypt: RTL and testbench
===============================

Name: arc4_encrypt

Overview:
- RC4 (ARC4) encryptor, the writer counterpart to the crack/decrypt path: takes a 24-bit key and a length-prefixed plaintext message and writes the length-prefixed ciphertext into ciphertext memory.
- The ciphertext it produces is the input the crack engine reads through ct_mem.
- Uses external single-port memories: S (state, 256x8, read/write), pt (plaintext, read) and ct (ciphertext, write).
- Starts through the same en/rdy handshake the lab top uses for the crack engine.

Parameters:
- KEY_BYTES, 3, key length in bytes. Key byte n is key[8*(KEY_BYTES-n)-1 -: 8]; byte 0 is key[23:16].

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  high when idle and able to accept en
- key  in  24  key, latched on en&rdy
- s_addr  out  8  S memory address
- s_rddata  in  8  S memory read data
- s_wrdata  out  8  S memory write data
- s_wren  out  1  S memory write enable
- pt_addr  out  8  plaintext memory address
- pt_rddata  in  8  plaintext read data
- ct_addr  out  8  ciphertext memory address
- ct_wrdata  out  8  ciphertext write data
- ct_wren  out  1  ciphertext write enable

Behaviour:
- Reset values: rdy=1, s_wren=0, ct_wren=0, all addresses and write data 0, state IDLE, i=j=k=0.
- Memory timing: all reads are synchronous. Data is valid on the clock edge after the address is presented (1-cycle latency). Writes commit on the edge where wren=1.
- Handshake:
  - en&rdy in IDLE latches key, and rdy falls on the next cycle.
  - en while rdy=0 is ignored.
  - rdy rises after the final ct write commits. The block then returns to IDLE.
  - A new en is accepted in the same cycle that rdy is observed high.
- State INIT: writes S[i]=i for i=0..255, one write per cycle, 256 cycles.
- State KSA: for i=0..255:
  - j = j + S[i] + keybyte[i mod KEY_BYTES], all arithmetic mod 256.
  - Swap S[i] and S[j] using two reads then two writes.
  - When i==j the two writes carry the same value and the result is still correct.
- State LEN:
  - Read pt[0] to get the length L.
  - Write ct[0]=L.
  - Reset i=j=0.
- State PRGA: for k=1..L:
  - i=i+1.
  - Read S[i]; j=j+S[i].
  - Read S[j]; write S[i]=S[j] and S[j]=old S[i].
  - Read S[(S[i]+S[j]) mod 256] as the pad, using the post-swap values.
  - Read pt[k].
  - Write ct[k] = pad ^ pt[k].
- Sub-states: each PRGA iteration and each KSA step is a fixed sub-state sequence (address, wait, capture). Exact cycle count is implementation-defined but must be constant per iteration.
- Boundaries:
  - L=0: only ct[0]=0 is written, then DONE.
  - L=255: k ends at 255 with no address wrap; ct[255] is written.
  - Counters i and j wrap mod 256.
  - wren strobes are single-cycle.
  - No ct write ever occurs to an address greater than L.
- Reset mid-operation: abort immediately to IDLE with reset values. Memory contents are left as-is, and no further writes occur.
- Only one memory write per port per cycle. s_wren and reads of S never target conflicting addresses in the same cycle.

Test Plan:
1. key=24'h4B6579 ("Key"), pt = 09,"Plaintext" -> ct = 09 BB F3 16 E8 D9 40 AF 0A D3. rdy returns high and stays high.
2. key=24'h000000, pt[0]=00 -> exactly one ct write (ct[0]=00). No PRGA S writes occur. rdy=1 afterwards.
3. Round trip: encrypt a random message under key=24'h1E4600, then re-run with ct copied into pt -> the output equals the original plaintext byte-for-byte, length 255 included.
4. Pulse en repeatedly while rdy=0 mid-KSA -> no restart. Final ct matches the single-run model.
5. Assert rst_n low during PRGA -> next cycle rdy=1 and both wren=0. A subsequent en with test-1 inputs reproduces the test-1 output.
6. After INIT, snoop S -> S[x]=x for all x. After KSA with test-1 key, S matches a software RC4 KSA model.

Source files
------------

// File: rtl/arc4_encrypt_if.sv
// ---------------------------------------------------------------------------
// arc4_encrypt_if
// Bundles the start handshake and the three memory buses of the RC4
// encryptor.
//   en, key            : start request and key, driven by the host
//   rdy                : idle/ready, driven by the encryptor
//   s_addr/s_wrdata/s_wren, s_rddata   : S state memory (256x8, r/w)
//   pt_addr, pt_rddata                 : plaintext memory (read)
//   ct_addr/ct_wrdata/ct_wren          : ciphertext memory (write)
// modport master : host / memory side
// modport slave  : encryptor side
// ---------------------------------------------------------------------------
interface arc4_encrypt_if #(
   parameter int KEY_BYTES = 3
);
   logic                   en;
   logic                   rdy;
   logic [8*KEY_BYTES-1:0] key;
   logic [7:0]             s_addr;
   logic [7:0]             s_rddata;
   logic [7:0]             s_wrdata;
   logic                   s_wren;
   logic [7:0]             pt_addr;
   logic [7:0]             pt_rddata;
   logic [7:0]             ct_addr;
   logic [7:0]             ct_wrdata;
   logic                   ct_wren;

   modport master (
      output en, key, s_rddata, pt_rddata,
      input  rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
   );

   modport slave (
      input  en, key, s_rddata, pt_rddata,
      output rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
   );
endinterface

// File: rtl/arc4_encrypt.sv
// ---------------------------------------------------------------------------
// arc4_encrypt
// RC4 encryptor: on en&rdy latches the key, initialises S, runs the key
// schedule, then reads the length-prefixed plaintext and writes the
// length-prefixed ciphertext.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (aborts any run, returns to IDLE)
//   bus   : arc4_encrypt_if.slave (handshake, S, pt and ct memory buses)
// All memory reads have one cycle of latency after the registered address
// becomes visible, so every read is an address / wait / capture triple.
// ---------------------------------------------------------------------------
module arc4_encrypt #(
   parameter int KEY_BYTES = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   arc4_encrypt_if.slave bus
);
   localparam int KW = 8 * KEY_BYTES;

   typedef enum logic [4:0] {
      ST_IDLE, ST_INIT,
      ST_KSA_RI, ST_KSA_WI, ST_KSA_CI, ST_KSA_WJ, ST_KSA_CJ, ST_KSA_WR,
      ST_LEN_A, ST_LEN_W, ST_LEN_C,
      ST_P_I, ST_P_WI, ST_P_CI, ST_P_WJ, ST_P_CJ, ST_P_WR,
      ST_P_PA, ST_P_WP, ST_P_CP,
      ST_DONE
   } state_t;

   state_t        state_q;
   logic [KW-1:0] key_q;
   logic [7:0]    i_q, j_q, k_q, len_q, si_q, sj_q;
   logic          rdy_q;
   logic [7:0]    s_addr_q, s_wrdata_q, pt_addr_q, ct_addr_q, ct_wrdata_q;
   logic          s_wren_q, ct_wren_q;

   logic [7:0]    ksa_j_d, prga_i_d, prga_j_d, pad_addr_d;

   // Index arithmetic shared by the key schedule and the keystream loop (mod 256).
   always_comb begin
      // The key register is rotated after every use, so the current key byte is always the top byte.
      ksa_j_d    = j_q + bus.s_rddata + key_q[KW-1 -: 8];
      prga_i_d   = i_q + 8'd1;
      prga_j_d   = j_q + bus.s_rddata;
      // S[i]+S[j] is symmetric, so the pre-swap captures give the post-swap pad address.
      pad_addr_d = si_q + sj_q;
   end

   // Control FSM with registered memory and handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         key_q       <= '0;
         i_q         <= 8'd0;
         j_q         <= 8'd0;
         k_q         <= 8'd0;
         len_q       <= 8'd0;
         si_q        <= 8'd0;
         sj_q        <= 8'd0;
         rdy_q       <= 1'b1;
         s_addr_q    <= 8'd0;
         s_wrdata_q  <= 8'd0;
         s_wren_q    <= 1'b0;
         pt_addr_q   <= 8'd0;
         ct_addr_q   <= 8'd0;
         ct_wrdata_q <= 8'd0;
         ct_wren_q   <= 1'b0;
      end else begin
         // Write strobes are single-cycle unless a state re-asserts them.
         s_wren_q  <= 1'b0;
         ct_wren_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               rdy_q <= 1'b1;
               if (bus.en && rdy_q) begin
                  key_q   <= bus.key;
                  rdy_q   <= 1'b0;
                  i_q     <= 8'd0;
                  j_q     <= 8'd0;
                  k_q     <= 8'd0;
                  state_q <= ST_INIT;
               end
            end
            ST_INIT: begin
               s_addr_q   <= i_q;
               s_wrdata_q <= i_q;
               s_wren_q   <= 1'b1;
               i_q        <= i_q + 8'd1;
               if (i_q == 8'd255) state_q <= ST_KSA_RI;
            end
            ST_KSA_RI: begin
               s_addr_q <= i_q;
               state_q  <= ST_KSA_WI;
            end
            ST_KSA_WI: state_q <= ST_KSA_CI;
            ST_KSA_CI: begin
               si_q     <= bus.s_rddata;
               j_q      <= ksa_j_d;
               s_addr_q <= ksa_j_d;
               key_q    <= (key_q << 8) | (key_q >> (KW - 8));
               state_q  <= ST_KSA_WJ;
            end
            ST_KSA_WJ: state_q <= ST_KSA_CJ;
            ST_KSA_CJ: begin
               sj_q       <= bus.s_rddata;
               s_addr_q   <= i_q;
               s_wrdata_q <= bus.s_rddata;
               s_wren_q   <= 1'b1;
               state_q    <= ST_KSA_WR;
            end
            ST_KSA_WR: begin
               // When i==j this rewrites the same byte with the same value.
               s_addr_q   <= j_q;
               s_wrdata_q <= si_q;
               s_wren_q   <= 1'b1;
               i_q        <= i_q + 8'd1;
               state_q    <= (i_q == 8'd255) ? ST_LEN_A : ST_KSA_RI;
            end
            ST_LEN_A: begin
               pt_addr_q <= 8'd0;
               i_q       <= 8'd0;
               j_q       <= 8'd0;
               state_q   <= ST_LEN_W;
            end
            ST_LEN_W: state_q <= ST_LEN_C;
            ST_LEN_C: begin
               len_q       <= bus.pt_rddata;
               ct_addr_q   <= 8'd0;
               ct_wrdata_q <= bus.pt_rddata;
               ct_wren_q   <= 1'b1;
               k_q         <= 8'd1;
               state_q     <= (bus.pt_rddata == 8'd0) ? ST_DONE : ST_P_I;
            end
            ST_P_I: begin
               // pt[k] is fetched now and stays on pt_rddata until the final capture.
               i_q       <= prga_i_d;
               s_addr_q  <= prga_i_d;
               pt_addr_q <= k_q;
               state_q   <= ST_P_WI;
            end
            ST_P_WI: state_q <= ST_P_CI;
            ST_P_CI: begin
               si_q     <= bus.s_rddata;
               j_q      <= prga_j_d;
               s_addr_q <= prga_j_d;
               state_q  <= ST_P_WJ;
            end
            ST_P_WJ: state_q <= ST_P_CJ;
            ST_P_CJ: begin
               sj_q       <= bus.s_rddata;
               s_addr_q   <= i_q;
               s_wrdata_q <= bus.s_rddata;
               s_wren_q   <= 1'b1;
               state_q    <= ST_P_WR;
            end
            ST_P_WR: begin
               s_addr_q   <= j_q;
               s_wrdata_q <= si_q;
               s_wren_q   <= 1'b1;
               state_q    <= ST_P_PA;
            end
            ST_P_PA: begin
               s_addr_q <= pad_addr_d;
               state_q  <= ST_P_WP;
            end
            ST_P_WP: state_q <= ST_P_CP;
            ST_P_CP: begin
               ct_addr_q   <= k_q;
               ct_wrdata_q <= bus.s_rddata ^ bus.pt_rddata;
               ct_wren_q   <= 1'b1;
               if (k_q == len_q) begin
                  state_q <= ST_DONE;
               end else begin
                  k_q     <= k_q + 8'd1;
                  state_q <= ST_P_I;
               end
            end
            ST_DONE: begin
               // The last ct write commits on the same edge that raises rdy.
               rdy_q   <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: begin
               rdy_q   <= 1'b1;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.rdy       = rdy_q;
   assign bus.s_addr    = s_addr_q;
   assign bus.s_wrdata  = s_wrdata_q;
   assign bus.s_wren    = s_wren_q;
   assign bus.pt_addr   = pt_addr_q;
   assign bus.ct_addr   = ct_addr_q;
   assign bus.ct_wrdata = ct_wrdata_q;
   assign bus.ct_wren   = ct_wren_q;
endmodule

// File: tb/tb_arc4_encrypt.sv
// ---------------------------------------------------------------------------
// tb_arc4_encrypt
// Bench for arc4_encrypt: models the S, pt and ct memories, drives the
// handshake, and compares ciphertext and S snapshots against a plain
// software RC4 model.
// ---------------------------------------------------------------------------
module tb_arc4_encrypt;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   arc4_encrypt_if bus();

   arc4_encrypt dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [7:0] s_mem  [256];
   logic [7:0] pt_mem [256];
   logic [7:0] ct_mem [256];
   logic [7:0] exp_ct [256];
   logic [7:0] exp_s  [256];
   logic [7:0] orig   [256];
   logic [7:0] s_rd, pt_rd;
   int s_wr_cnt = 0;
   int ct_wr_cnt = 0;
   int ct_over = 0;
   int ct_dbl = 0;
   logic ct_wren_prev = 1'b0;

   int total = 0;
   int bad = 0;

   localparam logic [23:0] K1 = 24'h4B6579;
   logic [7:0] t1_pt [10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
   logic [7:0] t1_ct [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

   assign bus.s_rddata  = s_rd;
   assign bus.pt_rddata = pt_rd;

   // Synchronous-read memories plus write monitors.
   always @(posedge clk) begin
      s_rd  <= s_mem[bus.s_addr];
      pt_rd <= pt_mem[bus.pt_addr];
      if (bus.s_wren) begin
         s_mem[bus.s_addr] <= bus.s_wrdata;
         s_wr_cnt <= s_wr_cnt + 1;
      end
      if (bus.ct_wren) begin
         ct_mem[bus.ct_addr] <= bus.ct_wrdata;
         ct_wr_cnt <= ct_wr_cnt + 1;
         if (bus.ct_addr > pt_mem[0]) ct_over <= ct_over + 1;
         if (ct_wren_prev) ct_dbl <= ct_dbl + 1;
      end
      ct_wren_prev <= bus.ct_wren;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Plain software RC4 over pt_mem: fills exp_s (post-KSA) and exp_ct.
   task automatic model_run(input logic [23:0] k);
      int s [256];
      int i, j, t, kb, len;
      for (int x = 0; x < 256; x++) s[x] = x;
      j = 0;
      for (i = 0; i < 256; i++) begin
         kb = int'((k >> (8 * (2 - (i % 3)))) & 24'hFF);
         j = (j + s[i] + kb) % 256;
         t = s[i]; s[i] = s[j]; s[j] = t;
      end
      for (int x = 0; x < 256; x++) exp_s[x] = 8'(s[x]);
      len = int'(pt_mem[0]);
      exp_ct[0] = pt_mem[0];
      i = 0;
      j = 0;
      for (int n = 1; n <= len; n++) begin
         i = (i + 1) % 256;
         j = (j + s[i]) % 256;
         t = s[i]; s[i] = s[j]; s[j] = t;
         exp_ct[n] = 8'(s[(s[i] + s[j]) % 256]) ^ pt_mem[n];
      end
   endtask

   task automatic start(input logic [23:0] k);
      int n = 0;
      while (bus.rdy !== 1'b1 && n < 6000) begin
         @(negedge clk);
         n++;
      end
      chk("start_rdy", 32'(bus.rdy), 32'd1);
      bus.key = k;
      bus.en  = 1'b1;
      @(negedge clk);
      bus.en  = 1'b0;
      chk("rdy_fall", 32'(bus.rdy), 32'd0);
   endtask

   task automatic wait_done();
      int n = 0;
      while (bus.rdy !== 1'b1 && n < 6000) begin
         @(negedge clk);
         n++;
      end
      chk("done_in_time", 32'(n < 6000), 32'd1);
   endtask

   task automatic wait_swr(input int target, input int base);
      int n = 0;
      while ((s_wr_cnt - base) < target && n < 6000) begin
         @(negedge clk);
         n++;
      end
      chk("swr_in_time", 32'(n < 6000), 32'd1);
   endtask

   task automatic load_t1();
      for (int n = 0; n < 10; n++) pt_mem[n] = t1_pt[n];
   endtask

   task automatic load_random(input int len);
      pt_mem[0] = 8'(len);
      for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom);
   endtask

   task automatic run_check(input string tag, input logic [23:0] k);
      int c0, len;
      model_run(k);
      len = int'(pt_mem[0]);
      c0 = ct_wr_cnt;
      start(k);
      bus.key = 24'($urandom);
      wait_done();
      for (int n = 0; n <= len; n++) chk($sformatf("%s_ct[%0d]", tag, n), 32'(ct_mem[n]), 32'(exp_ct[n]));
      chk($sformatf("%s_ct_writes", tag), 32'(ct_wr_cnt - c0), 32'(len + 1));
      chk("ct_addr_over_len", 32'(ct_over), 32'd0);
      chk("ct_wren_double", 32'(ct_dbl), 32'd0);
   endtask

   initial begin
      int s0, c0, nm;
      bus.en  = 1'b0;
      bus.key = 24'h000000;

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_rdy", 32'(bus.rdy), 32'd1);
      chk("rst_s_wren", 32'(bus.s_wren), 32'd0);
      chk("rst_ct_wren", 32'(bus.ct_wren), 32'd0);
      chk("rst_s_addr", 32'(bus.s_addr), 32'd0);
      chk("rst_s_wrdata", 32'(bus.s_wrdata), 32'd0);
      chk("rst_pt_addr", 32'(bus.pt_addr), 32'd0);
      chk("rst_ct_addr", 32'(bus.ct_addr), 32'd0);
      chk("rst_ct_wrdata", 32'(bus.ct_wrdata), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Known-answer vector, with S snooped after INIT and after KSA.
      load_t1();
      model_run(K1);
      s0 = s_wr_cnt;
      c0 = ct_wr_cnt;
      start(K1);
      bus.key = 24'hA5A5A5;
      wait_swr(256, s0);
      nm = 0;
      for (int x = 0; x < 256; x++) if (s_mem[x] !== 8'(x)) nm++;
      chk("init_S_bad_entries", 32'(nm), 32'd0);
      wait_swr(768, s0);
      nm = 0;
      for (int x = 0; x < 256; x++) if (s_mem[x] !== exp_s[x]) nm++;
      chk("ksa_S_bad_entries", 32'(nm), 32'd0);
      wait_done();
      for (int n = 0; n < 10; n++) chk($sformatf("t1_ct[%0d]", n), 32'(ct_mem[n]), 32'(t1_ct[n]));
      chk("t1_ct_writes", 32'(ct_wr_cnt - c0), 32'd10);
      repeat (3) begin
         @(negedge clk);
         chk("t1_rdy_stays", 32'(bus.rdy), 32'd1);
      end

      // Zero-length message.
      pt_mem[0] = 8'h00;
      s0 = s_wr_cnt;
      c0 = ct_wr_cnt;
      start(24'h000000);
      wait_done();
      chk("l0_ct_writes", 32'(ct_wr_cnt - c0), 32'd1);
      chk("l0_ct0", 32'(ct_mem[0]), 32'd0);
      chk("l0_s_writes", 32'(s_wr_cnt - s0), 32'd768);
      @(negedge clk);
      chk("l0_rdy", 32'(bus.rdy), 32'd1);

      // Round trip at the maximum length.
      load_random(255);
      for (int n = 0; n < 256; n++) orig[n] = pt_mem[n];
      run_check("rt_enc", 24'h1E4600);
      for (int n = 0; n < 256; n++) pt_mem[n] = ct_mem[n];
      c0 = ct_wr_cnt;
      start(24'h1E4600);
      wait_done();
      for (int n = 0; n < 256; n++) chk($sformatf("rt_dec[%0d]", n), 32'(ct_mem[n]), 32'(orig[n]));
      chk("rt_dec_writes", 32'(ct_wr_cnt - c0), 32'd256);

      // en pulses while busy in KSA are ignored.
      load_random(int'($urandom_range(1, 40)));
      begin
         logic [23:0] k4;
         int len4;
         k4 = 24'($urandom);
         len4 = int'(pt_mem[0]);
         model_run(k4);
         s0 = s_wr_cnt;
         c0 = ct_wr_cnt;
         start(k4);
         wait_swr(300, s0);
         repeat (5) begin
            bus.key = 24'($urandom);
            bus.en  = 1'b1;
            @(negedge clk);
            chk("busy_rdy_low", 32'(bus.rdy), 32'd0);
            bus.en  = 1'b0;
            @(negedge clk);
         end
         wait_done();
         for (int n = 0; n <= len4; n++) chk($sformatf("busy_ct[%0d]", n), 32'(ct_mem[n]), 32'(exp_ct[n]));
         chk("busy_ct_writes", 32'(ct_wr_cnt - c0), 32'(len4 + 1));
      end

      // Reset during PRGA, then rerun the known-answer vector.
      load_t1();
      s0 = s_wr_cnt;
      start(K1);
      wait_swr(774, s0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rdy", 32'(bus.rdy), 32'd1);
      chk("mid_rst_s_wren", 32'(bus.s_wren), 32'd0);
      chk("mid_rst_ct_wren", 32'(bus.ct_wren), 32'd0);
      s0 = s_wr_cnt;
      c0 = ct_wr_cnt;
      repeat (3) @(negedge clk);
      chk("mid_rst_no_s_writes", 32'(s_wr_cnt - s0), 32'd0);
      chk("mid_rst_no_ct_writes", 32'(ct_wr_cnt - c0), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      run_check("after_rst", K1);
      for (int n = 0; n < 10; n++) chk($sformatf("after_rst_kat[%0d]", n), 32'(ct_mem[n]), 32'(t1_ct[n]));

      // Random keys and lengths.
      repeat (2) begin
         load_random(int'($urandom_range(1, 254)));
         run_check("rand", 24'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
